// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES output path: block type, word width,
// serializer FSM states and the block-to-word selection function.
package aes_pkg;

  localparam int AES_N      = 16;
  localparam int AES_WORD_W = 32;

  typedef logic [AES_N-1:0][7:0] aes_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Word k of a block is bytes 4k..4k+3 with byte 4k in the least significant lane.
  function automatic logic [AES_WORD_W-1:0] aes_word(input aes_block_t blk,
                                                     input logic [1:0] idx);
    logic [AES_WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (idx == 2'(k)) begin
        w = {blk[4*k+3], blk[4*k+2], blk[4*k+1], blk[4*k]};
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Circular buffer of DEPTH ciphertext blocks with occupancy count.
// The caller guarantees push only when a slot is free and pop only when non-empty.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  aes_block_t               push_data_i,
  input  logic                     pop_i,
  output aes_block_t               rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  aes_block_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the output word reads zero before any capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(pop_i && count_q == '0)) else $error("aes_blk_fifo: pop while empty");
      assert (!(push_i && !pop_i && count_q == CW'(DEPTH))) else $error("aes_blk_fifo: push while full");
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers ciphertext blocks from the AES core and streams them as four 32-bit
// words per block over valid/ready, with full/empty/sticky-overflow status.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  done_in,
  input  aes_block_t            enc_data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            m_word_idx,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  ser_state_e    state_q, state_d;
  logic [1:0]    word_cnt_q, word_cnt_d;
  logic          ovf_q, ovf_d;
  logic          transfer, retire, slot_free, capture, drop;
  aes_block_t    rd_blk;
  logic [CW-1:0] count, count_next;
  logic          fifo_full, fifo_empty;

  // A full buffer still accepts a block when the head block retires this cycle.
  assign transfer   = m_valid && m_ready;
  assign retire     = transfer && (word_cnt_q == 2'd3);
  assign slot_free  = !fifo_full || retire;
  assign capture    = done_in && slot_free;
  assign drop       = done_in && !slot_free;
  assign count_next = count + CW'(capture) - CW'(retire);

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_blk_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (capture),
    .push_data_i (enc_data_in),
    .pop_i       (retire),
    .rd_data_o   (rd_blk),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (transfer) begin
      word_cnt_d = word_cnt_q + 2'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = SEND;
      SEND: if (retire && (count_next == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid    = (state_q == SEND);
    m_last     = m_valid && (word_cnt_q == 2'd3);
    m_word_idx = word_cnt_q;
    m_data     = aes_word(rd_blk, word_cnt_q);
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed scenarios with known
// words plus randomized traffic compared against a block-queue reference model.
module tb_aes_out_serializer;
  import aes_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        resetn;
  logic        done_in;
  aes_block_t  enc_data_in;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [1:0]  m_word_idx;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of whole blocks, word index within head block, sticky flag.
  aes_block_t modelQ[$];
  int         modelWordIdx;
  bit         modelOvf;

  aes_out_serializer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .done_in     (done_in),
    .enc_data_in (enc_data_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_word_idx  (m_word_idx),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input aes_block_t b, input int k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      w = w + (32'(b[4*k+j]) << (8*j));
    end
    return w;
  endfunction

  function automatic aes_block_t rand_block();
    aes_block_t b;
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'($urandom);
    end
    return b;
  endfunction

  task automatic model_reset();
    modelQ.delete();
    modelWordIdx = 0;
    modelOvf = 1'b0;
  endtask

  // Drive one clock cycle of inputs, advance the model by the same cycle, sample #1 after the edge.
  task automatic cycle(input logic d, input aes_block_t blk, input logic rdy, input logic clr);
    bit xfer, ret, free;
    done_in = d;
    enc_data_in = blk;
    m_ready = rdy;
    clr_ovf = clr;
    xfer = (modelQ.size() > 0) && rdy;
    ret = xfer && (modelWordIdx == 3);
    free = (modelQ.size() < DEPTH) || ret;
    if (ret) begin
      modelQ.delete(0);
      modelWordIdx = 0;
    end else if (xfer) begin
      modelWordIdx++;
    end
    if (d && free) modelQ.push_back(blk);
    if (d && !free) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    done_in = 1'b0;
    enc_data_in = '0;
    m_ready = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({m_valid, m_last, m_word_idx, full, empty, overflow} !== 7'b0000010) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=0000010",
               {m_valid, m_last, m_word_idx, full, empty, overflow});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h want=00000000", m_data);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    aes_block_t blk;
    logic [31:0] expW [4];
    expW = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    cycle(1'b1, blk, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({m_valid, m_data, m_last, m_word_idx} !== {1'b1, expW[k], (k == 3), 2'(k)}) begin
        failures++;
        $display("[TB] FAIL single_word%0d got v=%b d=%h l=%b i=%0d want v=1 d=%h l=%b i=%0d",
                 k, m_valid, m_data, m_last, m_word_idx, expW[k], (k == 3), k);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if ({m_valid, empty} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_drain got valid=%b empty=%b want valid=0 empty=1", m_valid, empty);
    end
  endtask

  task automatic test_backpressure();
    aes_block_t blk;
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    cycle(1'b1, blk, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({m_valid, m_data, m_word_idx, m_last} !== {1'b1, 32'h07060504, 2'd1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got v=%b d=%h i=%0d l=%b want v=1 d=07060504 i=1 l=0",
                 s, m_valid, m_data, m_word_idx, m_last);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if ({m_data, m_word_idx} !== {word_of(blk, k), 2'(k)}) begin
        failures++;
        $display("[TB] FAIL bp_resume%0d got d=%h i=%0d want d=%h i=%0d",
                 k, m_data, m_word_idx, word_of(blk, k), k);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_empty got=%b want=1", empty);
    end
  endtask

  task automatic test_back_to_back();
    aes_block_t a, b, cur;
    a = rand_block();
    b = rand_block();
    cycle(1'b1, a, 1'b1, 1'b0);
    checks++;
    if (m_data !== word_of(a, 0)) begin
      failures++;
      $display("[TB] FAIL b2b_w0 got=%h want=%h", m_data, word_of(a, 0));
    end
    cycle(1'b1, b, 1'b1, 1'b0);
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_full got=%b want=1", full);
    end
    for (int i = 1; i < 8; i++) begin
      cur = (i < 4) ? a : b;
      checks++;
      if ({m_valid, m_data, m_last} !== {1'b1, word_of(cur, i % 4), (i % 4 == 3)}) begin
        failures++;
        $display("[TB] FAIL b2b_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, m_valid, m_data, m_last, word_of(cur, i % 4), (i % 4 == 3));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if ({m_valid, empty} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL b2b_drain got valid=%b empty=%b want valid=0 empty=1", m_valid, empty);
    end
  endtask

  task automatic test_overflow();
    aes_block_t a, b, c, cur;
    a = rand_block();
    b = rand_block();
    c = rand_block();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_before got=%b want=0", overflow);
    end
    cycle(1'b1, c, 1'b0, 1'b0);
    checks++;
    if ({overflow, full} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ovf_set got ovf=%b full=%b want ovf=1 full=1", overflow, full);
    end
    for (int i = 0; i < 8; i++) begin
      cur = (i < 4) ? a : b;
      checks++;
      if ({m_valid, m_data} !== {1'b1, word_of(cur, i % 4)}) begin
        failures++;
        $display("[TB] FAIL ovf_word%0d got v=%b d=%h want v=1 d=%h",
                 i, m_valid, m_data, word_of(cur, i % 4));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if ({m_valid, empty, overflow} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL ovf_sticky got v=%b empty=%b ovf=%b want v=0 empty=1 ovf=1",
               m_valid, empty, overflow);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_simultaneous();
    aes_block_t a, b, c, cur;
    a = rand_block();
    b = rand_block();
    c = rand_block();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if ({m_last, full, m_data} !== {2'b11, word_of(a, 3)}) begin
      failures++;
      $display("[TB] FAIL sim_pre got l=%b full=%b d=%h want l=1 full=1 d=%h",
               m_last, full, m_data, word_of(a, 3));
    end
    cycle(1'b1, c, 1'b1, 1'b0);
    checks++;
    if ({overflow, full, m_word_idx, m_data} !== {1'b0, 1'b1, 2'd0, word_of(b, 0)}) begin
      failures++;
      $display("[TB] FAIL sim_capture got ovf=%b full=%b i=%0d d=%h want ovf=0 full=1 i=0 d=%h",
               overflow, full, m_word_idx, m_data, word_of(b, 0));
    end
    for (int i = 0; i < 8; i++) begin
      cur = (i < 4) ? b : c;
      checks++;
      if ({m_valid, m_data} !== {1'b1, word_of(cur, i % 4)}) begin
        failures++;
        $display("[TB] FAIL sim_word%0d got v=%b d=%h want v=1 d=%h",
                 i, m_valid, m_data, word_of(cur, i % 4));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if ({empty, overflow} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL sim_drain got empty=%b ovf=%b want empty=1 ovf=0", empty, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    aes_block_t a, b;
    a = rand_block();
    b = rand_block();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, rand_block(), 1'b0, 1'b0);
    cycle(1'b1, rand_block(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if ({m_word_idx, overflow, m_data} !== {2'd1, 1'b1, word_of(a, 1)}) begin
      failures++;
      $display("[TB] FAIL rst_pre got i=%0d ovf=%b d=%h want i=1 ovf=1 d=%h",
               m_word_idx, overflow, m_data, word_of(a, 1));
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_word_idx, full, empty, overflow, m_data} !== {7'b0000010, 32'd0}) begin
      failures++;
      $display("[TB] FAIL rst_async got v=%b l=%b i=%0d full=%b empty=%b ovf=%b d=%h want 0 0 0 0 1 0 00000000",
               m_valid, m_last, m_word_idx, full, empty, overflow, m_data);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    cycle(1'b1, b, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({m_valid, m_word_idx, m_data} !== {1'b1, 2'(k), word_of(b, k)}) begin
        failures++;
        $display("[TB] FAIL rst_after%0d got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                 k, m_valid, m_word_idx, m_data, k, word_of(b, k));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [6:0]  expFlags;
    logic [31:0] expData;
    bit          v;
    for (int c = 0; c < 600; c++) begin
      v = (modelQ.size() > 0);
      expFlags = {v, v && (modelWordIdx == 3), 2'(modelWordIdx),
                  (modelQ.size() == DEPTH), (modelQ.size() == 0), modelOvf};
      checks++;
      if ({m_valid, m_last, m_word_idx, full, empty, overflow} !== expFlags) begin
        failures++;
        $display("[TB] FAIL rand_flags cyc=%0d got=%b want=%b (v l idx full empty ovf)",
                 c, {m_valid, m_last, m_word_idx, full, empty, overflow}, expFlags);
      end
      if (v) begin
        expData = word_of(modelQ[0], modelWordIdx);
        checks++;
        if (m_data !== expData) begin
          failures++;
          $display("[TB] FAIL rand_data cyc=%0d got=%h want=%h", c, m_data, expData);
        end
      end
      cycle($urandom_range(0, 99) < 40, rand_block(), $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 5);
    end
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if ({m_valid, empty} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rand_drain got valid=%b empty=%b want valid=0 empty=1", m_valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Downstream of the AES-256 encryption core. Captures each 16-byte ciphertext block on the core's one-cycle `done` pulse and buffers up to `DEPTH` blocks. Streams the blocks out as four 32-bit words per block over a valid/ready interface toward the AXI read path. Reports full, empty and overflow status for the control register.

## Interface
- `DEPTH`, default 2: number of buffered 16-byte blocks. Legal values are 2 or 4 (power of two).
- `clk`  in  1: clock. All logic is rising-edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `done_in`  in  1: one-cycle pulse from the encryption core; `enc_data_in` is valid in this cycle.
- `enc_data_in`  in  [15:0][7:0]: ciphertext block, byte 0 to byte 15.
- `m_valid`  out  1: `m_data` holds a valid word.
- `m_ready`  in  1: the consumer accepts the word. A transfer is the cycle with `m_valid && m_ready`.
- `m_data`  out  32: current word.
- `m_last`  out  1: current word is word 3 of its block.
- `m_word_idx`  out  2: index of the current word within its block (0..3).
- `full`  out  1: `DEPTH` blocks are held.
- `empty`  out  1: no blocks are held.
- `overflow`  out  1: sticky; a block was dropped.
- `clr_ovf`  in  1: synchronous clear of `overflow`.

## Operation
- Storage is a circular buffer of `DEPTH` blocks.
  - `wr_ptr` and `rd_ptr` are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - `count` is 0..`DEPTH`.
  - `word_cnt` is 2 bits.
- Word packing: word k = {byte 4k+3, byte 4k+2, byte 4k+1, byte 4k}, so byte 4k sits in `m_data[7:0]`. Words are sent k = 0,1,2,3 in order.
- Capture: when `done_in` is high and a slot is free, store the block at `wr_ptr`, then increment `wr_ptr` and `count`.
  - A slot counts as free if `count < DEPTH`.
  - A slot also counts as free if, in the same cycle, `count == DEPTH` and a transfer with `m_last` occurs (the retiring slot is reused).
- Drop: when `done_in` is high and no slot is free, discard the block, leave the pointers unchanged and set `overflow`.
  - `overflow` stays set until a cycle with `clr_ovf` high.
  - If set and clear occur in the same cycle, set wins.
- Two-state FSM:
  - `IDLE` (`count == 0`): `m_valid = 0`. Go to `SEND` when a block is captured.
  - `SEND`: `m_valid = 1`. On each transfer, increment `word_cnt`.
  - On a transfer with `m_last`: reset `word_cnt` to 0, increment `rd_ptr` and decrement `count`. Return to `IDLE` only if the resulting `count` is 0.
- `count` update per cycle is capture(+1) plus retire(−1). Simultaneous capture and retire leaves `count` unchanged.
- Output signals:
  - `m_data` is the word at index `word_cnt` of block `rd_ptr`, taken from registered storage through a mux.
  - `m_last = (word_cnt == 3) && m_valid`.
  - `m_word_idx = word_cnt`.
- Status flags: `full = (count == DEPTH)` and `empty = (count == 0)`, both from registered `count`.
- Reset (asynchronous, mid-operation included) clears all of the following, and any partially sent block is discarded:
  - pointers, `count`, `word_cnt` and FSM state (to `IDLE`);
  - `overflow`;
  - storage contents, which reset to 0.
- Output values in reset: `m_valid = 0`, `m_data = 0`, `m_last = 0`, `m_word_idx = 0`, `full = 0`, `empty = 1`, `overflow = 0`.

## Timing
- Latency: `done_in` at cycle t into an empty buffer gives `m_valid = 1` with word 0 at t+1.
- Throughput: one word per cycle while `m_ready` is high. Consecutive buffered blocks stream with no bubble, so word 0 of the next block appears the cycle after the `m_last` transfer.
- Backpressure: while `m_valid && !m_ready`, `m_data`, `m_last` and `m_word_idx` hold stable.
- Data never depends combinationally on `m_ready`. `m_valid` is registered state; only the pointer and counter updates use `m_ready`.
- `full`, `empty` and `overflow` update one cycle after the event that causes them.
- `done_in` may arrive on any cycle, including back-to-back cycles.

## Structure
- The shared package `aes_pkg` holds:
  - `AES_N = 16` and `AES_WORD_W = 32`;
  - `typedef logic [AES_N-1:0][7:0] aes_block_t`;
  - the serializer FSM state enum (`IDLE`, `SEND`).
- One sub-module, `aes_blk_fifo`: `DEPTH`-entry block storage with `wr_ptr`, `rd_ptr` and `count`, push/pop inputs, and `full`/`empty`.
- The top module adds the word counter, the FSM, the word mux and the overflow flag.

## Test plan
- Single block: `done_in` with bytes 0x00..0x0F and `m_ready = 1` → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on cycles t+1..t+4; `m_last` only on the fourth; `empty` returns to 1.
- Backpressure: hold `m_ready = 0` for 3 cycles on word 1 → `m_data` stays 0x07060504 with `m_word_idx = 1`; the stream resumes without loss.
- Back-to-back: two `done_in` on consecutive cycles (blocks A, B) → 8 contiguous words A0..A3, B0..B3; `full` is 1 after the second capture when `DEPTH = 2`.
- Overflow: `m_ready = 0`, three `done_in` pulses → third block dropped, `overflow = 1`, first two blocks stream intact; `clr_ovf` → `overflow = 0`.
- Simultaneous: buffer full, `done_in` in the same cycle as the `m_last` transfer → block captured, `overflow` stays 0, `count` unchanged.
- Reset mid-stream: assert `resetn = 0` after word 1 → all outputs at their reset values immediately; after release, a new block streams from word 0.
